key_expander: RTL and testbench

//   Sequential AES-128 key schedule. Accepts a 128-bit cipher key, iterates the single-round

---
 rtl/aes_pkg.sv | 78 +++++++
 rtl/key_expander_keygen.sv | 35 +++
 rtl/key_expander.sv | 111 +++++++++++
 tb/tb_key_expander.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, controller state type and
// the GF(2^8) helpers that build the S-box without a lookup table.
package aes_pkg;

    localparam int AES_NR   = 10;
    localparam int AES_KW   = 128;
    localparam int RK_IDX_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = xtime(aa);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon(input logic [RK_IDX_W-1:0] rc);
        logic [7:0] r;
        case (rc)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_expander_keygen.sv
// One AES-128 KeyGen step: derives round key rc+1 from round key rc.
// Word w0 sits in kin[127:96].
module key_expander_keygen
    import aes_pkg::*;
(
    input  logic [RK_IDX_W-1:0] rc,
    input  logic [AES_KW-1:0]   kin,
    output logic [AES_KW-1:0]   kout
);

    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    logic [31:0] t;
    logic [31:0] w4;
    logic [31:0] w5;
    logic [31:0] w6;
    logic [31:0] w7;

    // Word recurrence of the key schedule.
    always_comb begin
        w0   = kin[127:96];
        w1   = kin[95:64];
        w2   = kin[63:32];
        w3   = kin[31:0];
        t    = sub_word(rot_word(w3)) ^ {rcon(rc), 24'h000000};
        w4   = w0 ^ t;
        w5   = w1 ^ w4;
        w6   = w2 ^ w5;
        w7   = w3 ^ w6;
        kout = {w4, w5, w6, w7};
    end

endmodule

// File: rtl/key_expander.sv
// Sequential AES-128 key schedule: one KeyGen step per clock into an
// 11-entry round-key buffer with a registered read port.
module key_expander
    import aes_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int KW = AES_KW
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KW-1:0]       key_in,
    output logic                ready,
    output logic                done,
    output logic                keys_valid,
    input  logic [RK_IDX_W-1:0] rd_addr,
    output logic [KW-1:0]       rd_key
);

    localparam logic [RK_IDX_W-1:0] RC_LAST = RK_IDX_W'(NR - 1);
    localparam logic [RK_IDX_W-1:0] RD_MAX  = RK_IDX_W'(NR);

    state_e              state_r;
    logic [RK_IDX_W-1:0] rc_r;
    logic [KW-1:0]       cur_r;
    logic                done_r;
    logic                keys_valid_r;
    logic [KW-1:0]       rd_key_r;
    logic [KW-1:0]       rk_r [0:NR];
    logic [KW-1:0]       nxt_s;
    logic                accept_s;
    logic                step_s;

    key_expander_keygen u_keygen (
        .rc   (rc_r),
        .kin  (cur_r),
        .kout (nxt_s)
    );

    // Decode buffer write enables from the controller state.
    always_comb begin
        accept_s = (state_r == ST_IDLE) && start;
        step_s   = (state_r == ST_EXPAND);
    end

    // Controller: load on accepted start, then step until the last round key.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            rc_r         <= {RK_IDX_W{1'b0}};
            cur_r        <= {KW{1'b0}};
            done_r       <= 1'b0;
            keys_valid_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        cur_r        <= key_in;
                        rc_r         <= {RK_IDX_W{1'b0}};
                        keys_valid_r <= 1'b0;
                        state_r      <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    cur_r <= nxt_s;
                    if (rc_r == RC_LAST) begin
                        rc_r         <= {RK_IDX_W{1'b0}};
                        done_r       <= 1'b1;
                        keys_valid_r <= 1'b1;
                        state_r      <= ST_IDLE;
                    end else begin
                        rc_r <= rc_r + RK_IDX_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Round-key buffer write port; contents are left untouched by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept_s) begin
                rk_r[0] <= key_in;
            end else if (step_s) begin
                rk_r[rc_r + RK_IDX_W'(1)] <= nxt_s;
            end
        end
    end

    // Registered read port; a same-edge write is not forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_key_r <= {KW{1'b0}};
        end else if (rd_addr <= RD_MAX) begin
            rd_key_r <= rk_r[rd_addr];
        end else begin
            rd_key_r <= {KW{1'b0}};
        end
    end

    assign ready      = (state_r == ST_IDLE);
    assign done       = done_r;
    assign keys_valid = keys_valid_r;
    assign rd_key     = rd_key_r;

endmodule

// File: tb/tb_key_expander.sv
// Directed bench for key_expander: a whole-schedule reference model revealed
// one round key per cycle, checked every cycle, plus FIPS-197 literals.
module tb_key_expander;

    localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KZ_R1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] KZ_RA = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] KFF   = {128{1'b1}};

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         ready;
    logic         done;
    logic         keys_valid;
    logic [3:0]   rd_addr;
    logic [127:0] rd_key;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [7:0]   sb [0:255];
    logic [127:0] m_key;
    logic [127:0] m_buf [0:10];
    bit           m_known [0:10] = '{default: 1'b0};
    int           m_cnt;
    bit           m_valid;
    bit           m_done;
    logic [127:0] m_rd;
    bit           m_rd_known;

    always #5 clk = ~clk;

    key_expander dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_in     (key_in),
        .ready      (ready),
        .done       (done),
        .keys_valid (keys_valid),
        .rd_addr    (rd_addr),
        .rd_key     (rd_key)
    );

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    // S-box from the 3-generator walk: p steps by *3, q by /3, q is the inverse of p.
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            sb[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] round_key(input logic [127:0] key, input int idx);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  r;
        r = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {r, 24'h0};
                r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
    endfunction

    // Reference behaviour: a start snapshots the key, then one round key appears per cycle.
    always @(posedge clk) begin
        if (rst) begin
            m_cnt      <= 0;
            m_valid    <= 1'b0;
            m_done     <= 1'b0;
            m_rd       <= 128'h0;
            m_rd_known <= 1'b1;
        end else begin
            if (rd_addr <= 4'd10) begin
                m_rd       <= m_buf[rd_addr];
                m_rd_known <= m_known[rd_addr];
            end else begin
                m_rd       <= 128'h0;
                m_rd_known <= 1'b1;
            end
            m_done <= 1'b0;
            if (m_cnt == 0) begin
                if (start) begin
                    m_key      <= key_in;
                    m_buf[0]   <= key_in;
                    m_known[0] <= 1'b1;
                    m_valid    <= 1'b0;
                    m_cnt      <= 10;
                end
            end else begin
                m_buf[11 - m_cnt]   <= round_key(m_key, 11 - m_cnt);
                m_known[11 - m_cnt] <= 1'b1;
                m_cnt               <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done  <= 1'b1;
                    m_valid <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 128'(ready), 128'(m_cnt == 0));
            chk("done", 128'(done), 128'(m_done));
            chk("keys_valid", 128'(keys_valid), 128'(m_valid));
            if (m_rd_known) chk("rd_key", rd_key, m_rd);
        end
    end

    task automatic do_start(input logic [127:0] k);
        @(posedge clk);
        #1;
        start  = 1'b1;
        key_in = k;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic rd(input logic [3:0] a, output logic [127:0] v);
        @(posedge clk);
        #1;
        rd_addr = a;
        @(posedge clk);
        @(negedge clk);
        v = rd_key;
    endtask

    initial begin
        int           lat;
        int           n;
        logic [127:0] v;
        logic [127:0] exp_v;

        build_sbox();
        rst = 1'b1;
        start = 1'b0;
        key_in = 128'h0;
        rd_addr = 4'd0;
        @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 128'(ready), 128'(1));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_keys_valid", 128'(keys_valid), 128'(0));
        chk("rst_rd_key", rd_key, 128'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        chk("model_k1_rk1", round_key(K1, 1), K1_R1);
        chk("model_k1_rk10", round_key(K1, 10), K1_RA);

        // T1: FIPS-197 A.1
        do_start(K1);
        wait_done(lat);
        chk("t1_latency", 128'(lat), 128'(10));
        rd(4'd1, v);  chk("t1_rk1", v, K1_R1);
        rd(4'd10, v); chk("t1_rk10", v, K1_RA);

        // T2: all-zero key
        do_start(128'h0);
        wait_done(lat);
        chk("t2_latency", 128'(lat), 128'(10));
        rd(4'd0, v);  chk("t2_rk0", v, 128'h0);
        rd(4'd1, v);  chk("t2_rk1", v, KZ_R1);
        rd(4'd10, v); chk("t2_rk10", v, KZ_RA);

        // T3: starts during expansion are ignored
        do_start(K1);
        n = 0;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            start  = (c == 2 || c == 6);
            key_in = (c == 2 || c == 6) ? KFF : K1;
            @(negedge clk);
            if (done) n++;
        end
        start = 1'b0;
        chk("t3_done_pulses", 128'(n), 128'(1));
        rd(4'd10, v); chk("t3_rk10", v, K1_RA);

        // T4: reset five cycles into an expansion
        do_start(K1);
        for (int c = 1; c <= 4; c++) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t4_ready", 128'(ready), 128'(1));
        chk("t4_keys_valid", 128'(keys_valid), 128'(0));
        n = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("t4_no_done", 128'(n), 128'(0));
        do_start(K1);
        wait_done(lat);
        chk("t4_latency", 128'(lat), 128'(10));
        rd(4'd10, v); chk("t4_rk10", v, K1_RA);

        // T5: read sweep over all 16 addresses
        for (int a = 0; a <= 16; a++) begin
            @(posedge clk);
            #1;
            if (a < 16) rd_addr = 4'(a);
            @(negedge clk);
            if (a == 1 || a == 2 || a == 11 || a >= 12) begin
                case (a - 1)
                    0:       exp_v = K1;
                    1:       exp_v = K1_R1;
                    10:      exp_v = K1_RA;
                    default: exp_v = 128'h0;
                endcase
                chk($sformatf("t5_rd_%0d", a - 1), rd_key, exp_v);
            end
        end

        // T6: start held high across done
        @(posedge clk);
        #1;
        start  = 1'b1;
        key_in = 128'h0;
        @(posedge clk);
        #1 key_in = K1;
        wait_done(lat);
        chk("t6_latency", 128'(lat), 128'(10));
        chk("t6_ready_at_done", 128'(ready), 128'(1));
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (keys_valid) break;
            n++;
        end
        chk("t6_kv_low_cycles", 128'(n), 128'(10));
        rd(4'd1, v);  chk("t6_rk1", v, K1_R1);
        rd(4'd10, v); chk("t6_rk10", v, K1_RA);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
